// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, write-data select, 31x32 register file, committed-write counter.
// Reads and wb_* are combinational with write-through; writes commit on the next clk edge; no backpressure.
module wb_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] WB_PCplus4,
  input  logic [19:0] WB_BranchAddr,
  input  logic [31:0] WB_immediate,
  input  logic        WB_cntl_RegWrite,
  input  logic [2:0]  WB_sel_MemToReg,
  input  logic [2:0]  WB_funct,
  input  logic [31:0] WB_ReadMemData,
  input  logic [31:0] WB_ALUResult,
  input  logic [4:0]  WB_WriteRegNum,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] instret
);

  logic [31:0] regs [1:31];
  logic [31:0] instret_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  always_comb begin
    ld_byte = WB_ReadMemData[7:0];
    case (WB_ALUResult[1:0])
      2'd1:    ld_byte = WB_ReadMemData[15:8];
      2'd2:    ld_byte = WB_ReadMemData[23:16];
      2'd3:    ld_byte = WB_ReadMemData[31:24];
      default: ld_byte = WB_ReadMemData[7:0];
    endcase
    // Halfword selection ignores address bit 0.
    ld_half = WB_ALUResult[1] ? WB_ReadMemData[31:16] : WB_ReadMemData[15:0];
    case (WB_funct)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = WB_ReadMemData;
    endcase
  end

  always_comb begin
    case (WB_sel_MemToReg)
      3'b000:  wb_data = WB_ALUResult;
      3'b001:  wb_data = load_data;
      3'b010:  wb_data = WB_immediate;
      3'b011:  wb_data = {12'h0, WB_BranchAddr};
      3'b100:  wb_data = {12'h0, WB_PCplus4};
      default: wb_data = 32'h0;
    endcase
  end

  assign wb_rd   = WB_WriteRegNum;
  assign wb_we   = WB_cntl_RegWrite && (WB_WriteRegNum != 5'd0) && (WB_sel_MemToReg <= 3'b100);
  assign instret = instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
      instret_q <= 32'h0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
      instret_q   <= instret_q + 32'd1;
    end
  end

  // Write-through lets decode see the value retiring in this same cycle.
  always_comb begin
    if (rs1_addr == 5'd0)                    rs1_data = 32'h0;
    else if (wb_we && (rs1_addr == wb_rd))   rs1_data = wb_data;
    else                                     rs1_data = regs[rs1_addr];
  end

  always_comb begin
    if (rs2_addr == 5'd0)                    rs2_data = 32'h0;
    else if (wb_we && (rs2_addr == wb_rd))   rs2_data = wb_data;
    else                                     rs2_data = regs[rs2_addr];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal cases plus randomized traffic against a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [19:0] WB_PCplus4, WB_BranchAddr;
  logic [31:0] WB_immediate, WB_ReadMemData, WB_ALUResult;
  logic        WB_cntl_RegWrite;
  logic [2:0]  WB_sel_MemToReg, WB_funct;
  logic [4:0]  WB_WriteRegNum, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, instret;
  logic        wb_we;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instret;

  wb_regfile dut (
    .clk(clk), .reset_n(reset_n),
    .WB_PCplus4(WB_PCplus4), .WB_BranchAddr(WB_BranchAddr), .WB_immediate(WB_immediate),
    .WB_cntl_RegWrite(WB_cntl_RegWrite), .WB_sel_MemToReg(WB_sel_MemToReg), .WB_funct(WB_funct),
    .WB_ReadMemData(WB_ReadMemData), .WB_ALUResult(WB_ALUResult), .WB_WriteRegNum(WB_WriteRegNum),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: loads as shifts and signed arithmetic on plain integers.
  function automatic logic [31:0] m_data();
    int unsigned b, h;
    b = (WB_ReadMemData >> (8 * WB_ALUResult[1:0])) & 32'hFF;
    h = (WB_ReadMemData >> (16 * WB_ALUResult[1])) & 32'hFFFF;
    case (WB_sel_MemToReg)
      3'd0: return WB_ALUResult;
      3'd1: begin
        case (WB_funct)
          3'd0:    return (b >= 128)   ? b - 256   : b;
          3'd4:    return b;
          3'd1:    return (h >= 32768) ? h - 65536 : h;
          3'd5:    return h;
          default: return WB_ReadMemData;
        endcase
      end
      3'd2: return WB_immediate;
      3'd3: return 32'(WB_BranchAddr);
      3'd4: return 32'(WB_PCplus4);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_we();
    return WB_cntl_RegWrite && WB_WriteRegNum != 0 && WB_sel_MemToReg <= 4;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == WB_WriteRegNum) return m_data();
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_instret = 32'h0;
    end else if (m_we()) begin
      m_regs[WB_WriteRegNum] = m_data();
      m_instret = m_instret + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wb_we", 32'(wb_we), 32'(m_we()));
      chk("wb_rd", 32'(wb_rd), 32'(WB_WriteRegNum));
      chk("wb_data", wb_data, m_data());
      chk("rs1_data", rs1_data, m_read(rs1_addr));
      chk("rs2_data", rs2_data, m_read(rs2_addr));
      chk("instret", instret, m_instret);
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [2:0]  lf [5];
  logic [1:0]  lo [5];
  logic [31:0] le [5];

  initial begin
    lf = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    lo = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    le = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80F1, 32'h00007F23, 32'h80F17F23};
    reset_n = 1'b0;
    WB_PCplus4 = '0; WB_BranchAddr = '0; WB_immediate = '0; WB_ReadMemData = '0;
    WB_ALUResult = '0; WB_cntl_RegWrite = 1'b0; WB_sel_MemToReg = '0; WB_funct = '0;
    WB_WriteRegNum = '0; rs1_addr = 5'd5; rs2_addr = 5'd31;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_instret = 32'h0;
    cmp_en = 1'b1;
    repeat (2) to_sample();
    chk("rst_instret", instret, 32'h0);
    chk("rst_x5", rs1_data, 32'h0);
    to_drive();
    reset_n = 1'b1;

    // Load extraction into x5
    for (int k = 0; k < 5; k++) begin
      WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b001; WB_funct = lf[k];
      WB_ReadMemData = 32'h80F17F23; WB_ALUResult = {30'h0, lo[k]};
      WB_WriteRegNum = 5'd5; rs1_addr = 5'd0;
      to_sample();
      chk("load_wb_data", wb_data, le[k]);
      to_drive();
      WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd5;
      to_sample();
      chk("load_x5", rs1_data, le[k]);
      to_drive();
    end

    // Same-cycle bypass on x7
    WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b000; WB_ALUResult = 32'h12345678;
    WB_WriteRegNum = 5'd7; rs1_addr = 5'd7;
    to_sample();
    chk("bypass_before", rs1_data, 32'h12345678);
    to_drive();
    WB_cntl_RegWrite = 1'b0;
    to_sample();
    chk("bypass_after", rs1_data, 32'h12345678);
    to_drive();

    // x0 protection
    WB_cntl_RegWrite = 1'b1; WB_WriteRegNum = 5'd0; WB_ALUResult = 32'hDEADBEEF; rs1_addr = 5'd0;
    to_sample();
    chk("x0_we", 32'(wb_we), 32'h0);
    chk("x0_read", rs1_data, 32'h0);
    to_drive();
    WB_cntl_RegWrite = 1'b0;
    to_sample();
    chk("x0_instret", instret, 32'd6);
    to_drive();

    // Select mux and zero extension on x1
    WB_cntl_RegWrite = 1'b1; WB_WriteRegNum = 5'd1; WB_sel_MemToReg = 3'b100; WB_PCplus4 = 20'hFFFFC;
    rs1_addr = 5'd2;
    to_drive();
    WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd1;
    to_sample();
    chk("mux_pc4", rs1_data, 32'h000FFFFC);
    to_drive();
    WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b011; WB_BranchAddr = 20'h00010; rs1_addr = 5'd2;
    to_drive();
    WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd1;
    to_sample();
    chk("mux_branch", rs1_data, 32'h00000010);
    to_drive();
    WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b110; WB_ALUResult = 32'hFFFFFFFF;
    to_sample();
    chk("mux_rsv_we", 32'(wb_we), 32'h0);
    chk("mux_rsv_data", wb_data, 32'h0);
    to_drive();
    WB_cntl_RegWrite = 1'b0;
    to_sample();
    chk("mux_rsv_x1", rs1_data, 32'h00000010);
    chk("mux_instret", instret, 32'd8);
    to_drive();

    // Randomized traffic, biased toward bypass hits and valid selects
    for (int n = 0; n < 2000; n++) begin
      WB_cntl_RegWrite = ($urandom_range(0, 3) != 0);
      WB_sel_MemToReg  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      WB_funct       = 3'($urandom);
      WB_ReadMemData = $urandom;
      WB_ALUResult   = $urandom;
      WB_immediate   = $urandom;
      WB_PCplus4     = 20'($urandom);
      WB_BranchAddr  = 20'($urandom);
      WB_WriteRegNum = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rs1_addr = ($urandom_range(0, 3) == 0) ? WB_WriteRegNum : 5'($urandom_range(0, 7));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom);
      to_drive();
    end

    // instret wrap
    WB_cntl_RegWrite = 1'b0;
    force dut.instret_q = 32'hFFFFFFFF;
    m_instret = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    to_sample();
    chk("wrap_pre", instret, 32'hFFFFFFFF);
    to_drive();
    WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b000; WB_WriteRegNum = 5'd2; WB_ALUResult = 32'h1;
    to_drive();
    WB_cntl_RegWrite = 1'b0;
    to_sample();
    chk("wrap_post", instret, 32'h0);
    to_drive();

    // Reset mid-operation
    WB_cntl_RegWrite = 1'b1; WB_sel_MemToReg = 3'b000; WB_ALUResult = 32'd5; WB_WriteRegNum = 5'd3;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    to_drive();
    WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd3;
    to_sample();
    chk("rstmid_x3", rs1_data, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_clr_x3", rs2_data, 32'h0);
    chk("rstmid_clr_cnt", instret, 32'h0);
    WB_cntl_RegWrite = 1'b1; WB_ALUResult = 32'd9; rs1_addr = 5'd4; rs2_addr = 5'd4;
    to_drive();
    WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd3;
    #1;
    chk("rstmid_drop", rs1_data, 32'h0);
    #1;
    reset_n = 1'b1;
    to_drive();
    WB_cntl_RegWrite = 1'b1; WB_ALUResult = 32'h77; rs1_addr = 5'd4;
    to_drive();
    WB_cntl_RegWrite = 1'b0; rs1_addr = 5'd3;
    to_sample();
    chk("rstmid_resume", rs1_data, 32'h77);
    chk("rstmid_cnt", instret, 32'd1);
    to_drive();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have clk, input, 1: rising-edge clock.
REQ-002 SHALL have reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have WB_PCplus4, input, 20: PC+4 of the retiring instruction.
REQ-004 SHALL have WB_BranchAddr, input, 20: branch/jump target of the retiring instruction.
REQ-005 SHALL have WB_immediate, input, 32: immediate value (LUI).
REQ-006 SHALL have WB_cntl_RegWrite, input, 1: register write request.
REQ-007 SHALL have WB_sel_MemToReg, input, 3: write-data select: 000 ALUResult, 001 load data, 010 immediate, 011 BranchAddr, 100 PC+4.
REQ-008 SHALL have WB_funct, input, 3: load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 SHALL have WB_ReadMemData, input, 32: full aligned memory word, little-endian.
REQ-010 SHALL have WB_ALUResult, input, 32: ALU result; bits [1:0] give the load byte offset.
REQ-011 SHALL have WB_WriteRegNum, input, 5: destination register (rd).
REQ-012 SHALL have rs1_addr, input, 5 and rs2_addr, input, 5: decode-stage read addresses.
REQ-013 SHALL have rs1_data, output, 32 and rs2_data, output, 32: combinational read data.
REQ-014 SHALL have wb_we, output, 1; wb_rd, output, 5; wb_data, output, 32: effective write, exported for forwarding.
REQ-015 SHALL have instret, output, 32: count of committed register writes.

Function
REQ-016 SHALL zero-extend WB_PCplus4 and WB_BranchAddr to 32 bits when they are selected.
REQ-017 SHALL form load data from byte offset o = WB_ALUResult[1:0]. LB/LBU: byte o, sign-extended or zero-extended. LH/LHU: halfword WB_ALUResult[1], sign-extended or zero-extended, with bit 0 ignored. LW and funct codes 011/110/111: the full word.
REQ-018 SHALL drive wb_data combinationally from the WB_sel_MemToReg mux; reserved codes 101-111 drive wb_data = 0.
REQ-019 SHALL set wb_we = WB_cntl_RegWrite AND (WB_WriteRegNum != 0) AND (WB_sel_MemToReg <= 100).
REQ-020 SHALL set wb_rd = WB_WriteRegNum at all times.
REQ-021 SHALL hold 31 32-bit registers x1-x31; x0 SHALL read as 0 and SHALL never be stored.
REQ-022 SHALL write wb_data into x[wb_rd] on the rising clk edge when wb_we = 1; the written value SHALL be visible from the next cycle.
REQ-023 SHALL make reads combinational: rsN_data = 0 if rsN_addr = 0; otherwise wb_data if wb_we and rsN_addr = wb_rd (same-cycle write-through bypass); otherwise x[rsN_addr].
REQ-024 SHALL apply REQ-023 to both ports independently; rs1_addr = rs2_addr SHALL return identical data.
REQ-025 SHALL increment instret by 1 on each clk edge where wb_we = 1, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL NOT count RegWrite to x0 or with a reserved select in instret, since wb_we = 0 in those cases.

Reset
REQ-027 SHALL clear x1-x31 and instret to 0 asynchronously while reset_n = 0.
REQ-028 SHALL drop any write coinciding with a reset assertion; the first write SHALL occur on the first rising edge after reset_n deasserts.
REQ-029 SHALL keep the combinational outputs (wb_*, rsN_data) as functions of their inputs during reset, with register contents reading 0.

Verification
REQ-030 SHALL cover load extraction: ReadMemData=0x80F17F23, sel=001, write x5:
- LB, offset 3 -> x5 = 0xFFFFFF80.
- LBU, offset 1 -> x5 = 0x0000007F.
- LH, offset 2 -> x5 = 0xFFFF80F1.
- LHU, offset 0 -> x5 = 0x00007F23.
- LW -> x5 = 0x80F17F23.
REQ-031 SHALL cover bypass: write x7=0x12345678 with rs1_addr=7 in the same cycle -> rs1_data = 0x12345678 before the edge, and still 0x12345678 after it with wb_we=0.
REQ-032 SHALL cover x0 protection: RegWrite=1, rd=0, ALUResult=0xDEADBEEF -> wb_we=0, rs1 read of x0 = 0, instret unchanged.
REQ-033 SHALL cover the select mux and extension: sel=100, PCplus4=0xFFFFC -> x1 = 0x000FFFFC; sel=011, BranchAddr=0x00010 -> x1 = 0x00000010; sel=110 -> wb_we=0 and x1 unchanged.
REQ-034 SHALL cover instret wrap: preload 0xFFFFFFFF by forcing or long run, one write -> instret = 0.
REQ-035 SHALL cover reset mid-operation: write x3=5, assert reset_n low mid-cycle -> x3 = 0 and instret = 0 immediately; after release, writes resume normally.
